// File: rtl/gray_code_counter.sv
// Registered WIDTH-bit reflected Gray sequence source with valid/ready output,
// synchronous load and wrap pulse. Define GRAY_STEP_CHECK_EN to add the sticky step_err monitor.
module gray_code_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] gray_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             wrap
`ifdef GRAY_STEP_CHECK_EN
  ,
  output logic             step_err
`endif
);

  function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             valid_q, valid_d;
  logic             wrap_q, wrap_d;
  logic             fire;
  logic             step;
  logic [WIDTH-1:0] bin_next;
  logic             wrap_step;

  assign fire      = valid_q & out_ready;
  assign bin_next  = up_dn ? bin_q + WIDTH'(1) : bin_q - WIDTH'(1);
  // A step wraps when it leaves the all-ones code going up or the zero code going down.
  assign wrap_step = up_dn ? (&bin_q) : ~(|bin_q);

  // NOTE: every output of this block gets a default first so no path leaves a latch.
  always_comb begin
    bin_d   = bin_q;
    gray_d  = gray_q;
    valid_d = valid_q;
    wrap_d  = 1'b0;
    step    = 1'b0;
    if (load) begin
      bin_d   = load_val;
      gray_d  = to_gray(load_val);
      valid_d = 1'b1;
    end else if (fire && en) begin
      bin_d   = bin_next;
      gray_d  = to_gray(bin_next);
      wrap_d  = wrap_step;
      step    = 1'b1;
    end else if (fire) begin
      valid_d = 1'b0;
    end else if (!valid_q && en) begin
      valid_d = 1'b1;
    end
  end

  // NOTE: sequential state is updated only with non-blocking assignments.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q   <= '0;
      gray_q  <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      bin_q   <= bin_d;
      gray_q  <= gray_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
    end
  end

  assign gray_out  = gray_q;
  assign out_valid = valid_q;
  assign wrap      = wrap_q;

`ifdef GRAY_STEP_CHECK_EN
  logic step_err_q, step_err_d;

  // Only counting steps are checked; loads may legally jump anywhere.
  always_comb begin
    step_err_d = step_err_q;
    if (step && ($countones(gray_d ^ gray_q) != 1))
      step_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) step_err_q <= 1'b0;
    else     step_err_q <= step_err_d;
  end

  assign step_err = step_err_q;
`endif

endmodule
